barrel_shift_arbiter: RTL and testbench

Shares one 8-bit left shift/rotate datapath between two requesters. Each requester has a valid/ready handshake; a round-robin arbiter grants one request per cycle. The granted operand is shifted through the internal three-layer barrel shifter (shift amounts 1, 2 and 4) and captured in a one-entry output register, which is drained by a valid/ready consumer. The block sits between the shift-command sources and the result consumer, and keeps a per-requester count of accepted operations.

---
 rtl/barrel_shift_arbiter.sv | 76 +++++++
 tb/tb_barrel_shift_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/barrel_shift_arbiter.sv
// Two-requester round-robin front end for one 8-bit shift/rotate-left datapath.
// Latency: result registered one cycle after accept; one result per cycle when drained.
// Backpressure: a full, undrained output register deasserts both readys.
module barrel_shift_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_x,
  input  logic [2:0] req0_amt,
  input  logic       req0_rot,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_x,
  input  logic [2:0] req1_amt,
  input  logic       req1_rot,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_z,
  output logic       out_id,
  output logic [7:0] cnt0,
  output logic [7:0] cnt1
);

  typedef struct packed {
    logic [7:0] x;
    logic [2:0] amt;
    logic       rot;
  } cmd_t;

  cmd_t       cmd0, cmd1, gcmd;
  logic       ptr;
  logic       grant;
  logic       can_accept;
  logic       accept;
  logic [7:0] s1, s2, s4;

  assign cmd0 = '{x: req0_x, amt: req0_amt, rot: req0_rot};
  assign cmd1 = '{x: req1_x, amt: req1_amt, rot: req1_rot};

  // Priority pointer only matters when both requesters contend.
  assign grant      = (req0_valid & req1_valid) ? ptr : req1_valid;
  assign can_accept = ~out_valid | out_ready;
  assign req0_ready = ~rst & can_accept & ~grant & req0_valid;
  assign req1_ready = ~rst & can_accept &  grant & req1_valid;
  assign accept     = req0_ready | req1_ready;
  assign gcmd       = grant ? cmd1 : cmd0;

  // Three log layers; each either rotates or zero-fills the vacated low bits.
  assign s1 = gcmd.amt[0] ? {gcmd.x[6:0], gcmd.rot ? gcmd.x[7]   : 1'b0} : gcmd.x;
  assign s2 = gcmd.amt[1] ? {s1[5:0],     gcmd.rot ? s1[7:6]     : 2'b00} : s1;
  assign s4 = gcmd.amt[2] ? {s2[3:0],     gcmd.rot ? s2[7:4]     : 4'b0000} : s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_z     <= 8'h00;
      out_id    <= 1'b0;
      ptr       <= 1'b0;
      cnt0      <= 8'h00;
      cnt1      <= 8'h00;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_z     <= s4;
        out_id    <= grant;
        ptr       <= ~grant;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (req0_ready) cnt0 <= cnt0 + 8'd1;
      if (req1_ready) cnt1 <= cnt1 + 8'd1;
    end
  end

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Bench for barrel_shift_arbiter: vector table, directed corner sequences, random traffic vs reference model.
module tb_barrel_shift_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req0_rot;
  logic [7:0] req0_x;
  logic [2:0] req0_amt;
  logic       req1_valid, req1_ready, req1_rot;
  logic [7:0] req1_x;
  logic [2:0] req1_amt;
  logic       out_valid, out_ready, out_id;
  logic [7:0] out_z, cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  // Reference state, updated from the behavioural rules at each clock edge.
  bit m_valid;
  int m_z;
  int m_id;
  int m_ptr;
  int m_cnt[2];
  bit last_acc0, last_acc1;

  barrel_shift_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x),
    .req0_amt(req0_amt), .req0_rot(req0_rot),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x),
    .req1_amt(req1_amt), .req1_rot(req1_rot),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
    .out_id(out_id), .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  function automatic int ref_shift(int x, int amt, bit rot);
    int l;
    l = (x << amt) & 255;
    if (rot) return l | ((x >> (8 - amt)) & 255);
    return l;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs are already driven (at a falling edge); check readys, clock once, check outputs.
  task automatic step();
    int w;
    int z;
    #1;
    w = -1;
    if (!rst && (!m_valid || out_ready)) begin
      if (req0_valid && req1_valid) w = m_ptr;
      else if (req0_valid) w = 0;
      else if (req1_valid) w = 1;
    end
    check("req0_ready", {31'd0, req0_ready}, w == 0);
    check("req1_ready", {31'd0, req1_ready}, w == 1);
    last_acc0 = (w == 0);
    last_acc1 = (w == 1);
    z = (w == 1) ? ref_shift(req1_x, req1_amt, req1_rot) : ref_shift(req0_x, req0_amt, req0_rot);
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_z = 0; m_id = 0; m_ptr = 0; m_cnt[0] = 0; m_cnt[1] = 0;
    end else if (w >= 0) begin
      m_valid = 1; m_z = z; m_id = w; m_ptr = 1 - w;
      m_cnt[w] = (m_cnt[w] + 1) % 256;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
    @(negedge clk);
    check("out_valid", {31'd0, out_valid}, m_valid);
    check("out_z", {24'd0, out_z}, m_z);
    check("out_id", {31'd0, out_id}, m_id);
    check("cnt0", {24'd0, cnt0}, m_cnt[0]);
    check("cnt1", {24'd0, cnt1}, m_cnt[1]);
  endtask

  typedef struct {
    bit       req;
    bit [7:0] x;
    bit [2:0] amt;
    bit       rot;
    bit [7:0] exp_z;
  } vec_t;

  vec_t vecs[7];

  initial begin
    bit [7:0] cexp[4];
    vecs[0] = '{0, 8'hCC, 3'd1, 1'b0, 8'h98};
    vecs[1] = '{1, 8'hCC, 3'd1, 1'b1, 8'h99};
    vecs[2] = '{1, 8'hCC, 3'd3, 1'b1, 8'h66};
    vecs[3] = '{1, 8'hCC, 3'd3, 1'b0, 8'h60};
    vecs[4] = '{1, 8'hCC, 3'd0, 1'b0, 8'hCC};
    vecs[5] = '{1, 8'hCC, 3'd0, 1'b1, 8'hCC};
    vecs[6] = '{1, 8'hCC, 3'd7, 1'b0, 8'h00};

    m_valid = 0; m_z = 0; m_id = 0; m_ptr = 0; m_cnt[0] = 0; m_cnt[1] = 0;
    rst = 1'b1; out_ready = 1'b1;
    req0_valid = 0; req0_x = 0; req0_amt = 0; req0_rot = 0;
    req1_valid = 0; req1_x = 0; req1_amt = 0; req1_rot = 0;
    @(negedge clk);
    step();
    rst = 1'b0;
    step();
    check("reset_out_valid", {31'd0, out_valid}, 0);
    check("reset_cnt0", {24'd0, cnt0}, 0);

    // Vector table: single op on requester 0, then mode sweep on requester 1.
    for (int i = 0; i < 7; i++) begin
      req0_valid = !vecs[i].req; req1_valid = vecs[i].req;
      req0_x = vecs[i].x; req0_amt = vecs[i].amt; req0_rot = vecs[i].rot;
      req1_x = vecs[i].x; req1_amt = vecs[i].amt; req1_rot = vecs[i].rot;
      #1;
      check("vec_ready", {31'd0, vecs[i].req ? req1_ready : req0_ready}, 1);
      step();
      check("vec_z", {24'd0, out_z}, {24'd0, vecs[i].exp_z});
      check("vec_id", {31'd0, out_id}, {31'd0, vecs[i].req});
      check("vec_valid", {31'd0, out_valid}, 1);
    end
    check("vec_cnt0", {24'd0, cnt0}, 1);
    check("vec_cnt1", {24'd0, cnt1}, 6);

    // Contention: alternating grants, one result per cycle.
    req0_valid = 1; req0_x = 8'h81; req0_amt = 3'd1; req0_rot = 1;
    req1_valid = 1; req1_x = 8'h81; req1_amt = 3'd4; req1_rot = 0;
    cexp[0] = 8'h03; cexp[1] = 8'h10; cexp[2] = 8'h03; cexp[3] = 8'h10;
    for (int i = 0; i < 4; i++) begin
      step();
      check("cont_id", {31'd0, out_id}, i % 2);
      check("cont_valid", {31'd0, out_valid}, 1);
      check("cont_z", {24'd0, out_z}, {24'd0, cexp[i]});
    end
    check("cont_cnt0", {24'd0, cnt0}, 3);
    check("cont_cnt1", {24'd0, cnt1}, 8);

    // Backpressure: frozen output, then drain and accept on the same edge.
    req0_valid = 0;
    req1_x = 8'h0F; req1_amt = 3'd2; req1_rot = 1;
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready", {31'd0, req1_ready}, 0);
      step();
      check("bp_z", {24'd0, out_z}, 8'h10);
      check("bp_id", {31'd0, out_id}, 1);
      check("bp_cnt1", {24'd0, cnt1}, 8);
    end
    out_ready = 1;
    #1;
    check("bp_release_ready", {31'd0, req1_ready}, 1);
    step();
    check("bp_new_z", {24'd0, out_z}, 8'h3C);
    check("bp_new_valid", {31'd0, out_valid}, 1);
    check("bp_new_cnt1", {24'd0, cnt1}, 9);

    // Counter wrap from a clean reset.
    req1_valid = 0;
    rst = 1; step(); rst = 0;
    req0_valid = 1;
    for (int i = 0; i < 256; i++) begin
      req0_x = 8'($urandom); req0_amt = 3'($urandom); req0_rot = 1'($urandom);
      step();
    end
    check("wrap_cnt0", {24'd0, cnt0}, 0);
    check("wrap_cnt1", {24'd0, cnt1}, 0);

    // Reset while a result is pending and stalled.
    out_ready = 0;
    step();
    check("pre_rst_valid", {31'd0, out_valid}, 1);
    rst = 1; req1_valid = 1;
    #1;
    check("rst_ready0", {31'd0, req0_ready}, 0);
    check("rst_ready1", {31'd0, req1_ready}, 0);
    step();
    rst = 0;
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_cnt0", {24'd0, cnt0}, 0);
    out_ready = 1;
    #1;
    check("post_rst_grant0", {31'd0, req0_ready}, 1);
    check("post_rst_grant1", {31'd0, req1_ready}, 0);
    step();

    // Random traffic; a pending request keeps its payload until accepted.
    for (int i = 0; i < 600; i++) begin
      if (!(req0_valid && !last_acc0)) begin
        req0_valid = 1'($urandom); req0_x = 8'($urandom);
        req0_amt = 3'($urandom); req0_rot = 1'($urandom);
      end
      if (!(req1_valid && !last_acc1)) begin
        req1_valid = 1'($urandom); req1_x = 8'($urandom);
        req1_amt = 3'($urandom); req1_rot = 1'($urandom);
      end
      out_ready = ($urandom_range(3) != 0);
      rst = ($urandom_range(60) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
